// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared mode constants and parameter check for the pipelined adder
package adder_pkg;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  function automatic bit width_ok(input int width, input int stages);
    return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// rtl/adder_slice.sv - combinational C-bit ripple adder slice with carry-into-MSB tap
module adder_slice #(
  parameter int C = 8
) (
  input  logic [C-1:0] A,
  input  logic [C-1:0] B,
  input  logic         Pin,
  output logic [C-1:0] S,
  output logic         Pout,
  output logic         Cmsb
);

  // Carry kept per bit rather than in one packed vector so the chain is not a self-referencing signal.
  for (genvar i = 0; i < C; i++) begin : g_bit
    logic ci;
    logic co;
    if (i == 0) begin : g_cin
      assign ci = Pin;
    end else begin : g_cin
      assign ci = g_bit[i-1].co;
    end
    fulladder u_fa (
      .a  (A[i]),
      .b  (B[i]),
      .ci (ci),
      .s  (S[i]),
      .co (co)
    );
  end

  assign Pout = g_bit[C-1].co;
  assign Cmsb = g_bit[C-1].ci;

endmodule

// File: rtl/fulladder.sv
// rtl/fulladder.sv - single-bit full adder cell
module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - STAGES-deep pipelined add/subtract with valid/ready handshakes
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Pin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Pout,
  output logic             Ovf
);

  localparam int C = WIDTH / STAGES;

  if (!width_ok(WIDTH, STAGES)) begin : g_width_check
    $error("pipelined_adder: WIDTH (%0d) must be a positive multiple of STAGES (%0d)", WIDTH, STAGES);
  end

  logic advance;

  // Stage k keeps only the operand bits still to be added and the sum bits already produced.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO  = k * C;
    localparam int REM = WIDTH - LO;

    logic [REM-1:0]  a_in;
    logic [REM-1:0]  b_in;
    logic            c_in;
    logic            v_in;
    logic [C-1:0]    sum;
    logic            cout;
    logic [LO+C-1:0] s_d;
    logic [LO+C-1:0] s_q;
    logic            v_q;

    if (k == 0) begin : g_src
      assign a_in = A;
      assign b_in = (Sub == SUB) ? ~B : B;
      assign c_in = (Sub == SUB) ? 1'b1 : Pin;
      assign v_in = in_valid;
      assign s_d  = sum;
    end else begin : g_src
      assign a_in = g_stage[k-1].g_skew.a_q;
      assign b_in = g_stage[k-1].g_skew.b_q;
      assign c_in = g_stage[k-1].g_skew.c_q;
      assign v_in = g_stage[k-1].v_q;
      assign s_d  = {sum, g_stage[k-1].s_q};
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        s_q <= '0;
      end else if (advance) begin
        v_q <= v_in;
        s_q <= s_d;
      end
    end

    if (k == STAGES - 1) begin : g_tail
      logic cmsb;
      logic pout_q;
      logic ovf_q;

      adder_slice #(.C(C)) u_slice (
        .A    (a_in[C-1:0]),
        .B    (b_in[C-1:0]),
        .Pin  (c_in),
        .S    (sum),
        .Pout (cout),
        .Cmsb (cmsb)
      );

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          pout_q <= 1'b0;
          ovf_q  <= 1'b0;
        end else if (advance) begin
          pout_q <= cout;
          ovf_q  <= cmsb ^ cout;
        end
      end
    end else begin : g_skew
      logic           unused_cmsb;
      logic           c_q;
      logic [REM-C-1:0] a_q;
      logic [REM-C-1:0] b_q;

      adder_slice #(.C(C)) u_slice (
        .A    (a_in[C-1:0]),
        .B    (b_in[C-1:0]),
        .Pin  (c_in),
        .S    (sum),
        .Pout (cout),
        .Cmsb (unused_cmsb)
      );

      always_ff @(posedge clk) begin
        if (advance) begin
          a_q <= a_in[REM-1:C];
          b_q <= b_in[REM-1:C];
          c_q <= cout;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign S         = g_stage[STAGES-1].s_q;
  assign Pout      = g_stage[STAGES-1].g_tail.pout_q;
  assign Ovf       = g_stage[STAGES-1].g_tail.ovf_q;
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - self-checking bench for pipelined_adder against an arithmetic model
module tb_pipelined_adder;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Pin;
  logic             Sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             Pout;
  logic             Ovf;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Pin       (Pin),
    .Sub       (Sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .Pout      (Pout),
    .Ovf       (Ovf)
  );

  typedef struct {
    logic [31:0] s;
    logic        p;
    logic        o;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          n_out = 0;
  int          n_in = 0;
  bit          track_lat = 0;
  bit          stalled_prev = 0;
  logic [31:0] prev_s;
  logic        prev_p;
  logic        prev_o;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic pin, input logic sub);
    exp_t        e;
    logic [32:0] u;
    longint      sr;
    if (sub) begin
      u   = {1'b0, a} - {1'b0, b};
      e.p = (a >= b);
      sr  = longint'($signed(a)) - longint'($signed(b));
    end else begin
      u   = {1'b0, a} + {1'b0, b} + {32'b0, pin};
      e.p = u[32];
      sr  = longint'($signed(a)) + longint'($signed(b)) + longint'(pin);
    end
    e.s   = u[31:0];
    e.o   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    e.acc = 0;
    return e;
  endfunction

  task automatic step();
    exp_t e;
    #1;
    if (rst_n) begin
      checks++;
      if (in_ready !== !(out_valid && !out_ready))
        begin errors++; $display("FAIL in_ready: got %b, want %b", in_ready, !(out_valid && !out_ready)); end
      if (stalled_prev) begin
        checks++;
        if (out_valid !== 1'b1 || S !== prev_s || Pout !== prev_p || Ovf !== prev_o)
          begin errors++; $display("FAIL stall_hold: got v=%b S=%h P=%b O=%b, want v=1 S=%h P=%b O=%b", out_valid, S, Pout, Ovf, prev_s, prev_p, prev_o); end
      end
      if (out_valid && out_ready) begin
        n_out++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL unexpected_output: got S=%h, want no output", S);
        end else begin
          e = exp_q.pop_front();
          if (S !== e.s || Pout !== e.p || Ovf !== e.o)
            begin errors++; $display("FAIL result: got S=%h P=%b O=%b, want S=%h P=%b O=%b", S, Pout, Ovf, e.s, e.p, e.o); end
          if (track_lat) begin
            checks++;
            if (cyc - e.acc != STAGES)
              begin errors++; $display("FAIL latency: got %0d, want %0d", cyc - e.acc, STAGES); end
          end
        end
      end
      if (in_valid && in_ready) begin
        e = model(A, B, Pin, Sub);
        e.acc = cyc;
        exp_q.push_back(e);
        n_in++;
      end
      stalled_prev = out_valid && !out_ready;
      prev_s = S;
      prev_p = Pout;
      prev_o = Ovf;
    end else begin
      exp_q.delete();
      stalled_prev = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive_rand(input bit v);
    A        = $urandom;
    B        = $urandom;
    Pin      = 1'($urandom_range(0, 1));
    Sub      = 1'($urandom_range(0, 1));
    in_valid = v;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; Pin = 1'b0; Sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, want 0", out_valid); end
    checks++; if (S !== 32'h0)        begin errors++; $display("FAIL reset_S: got %h, want 0", S); end
    checks++; if (Pout !== 1'b0)      begin errors++; $display("FAIL reset_Pout: got %b, want 0", Pout); end
    checks++; if (Ovf !== 1'b0)       begin errors++; $display("FAIL reset_Ovf: got %b, want 0", Ovf); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b, want 1", in_ready); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_directed(input string name, input logic [31:0] a, input logic [31:0] b,
                               input logic pin, input logic sub,
                               input logic [31:0] es, input logic ep, input logic eo);
    int n = 0;
    track_lat = 1; out_ready = 1'b1;
    A = a; B = b; Pin = pin; Sub = sub; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    while (!out_valid && n < 10) begin step(); n++; end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL %s_timeout: got no out_valid, want out_valid", name);
    end else begin
      if (S !== es || Pout !== ep || Ovf !== eo)
        begin errors++; $display("FAIL %s: got S=%h P=%b O=%b, want S=%h P=%b O=%b", name, S, Pout, Ovf, es, ep, eo); end
      checks++;
      if (n + 1 != STAGES) begin errors++; $display("FAIL %s_latency: got %0d, want %0d", name, n + 1, STAGES); end
    end
    step();
  endtask

  task automatic test_back_to_back();
    int out0 = n_out;
    track_lat = 1; out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin drive_rand(1'b1); step(); end
    in_valid = 1'b0;
    repeat (STAGES + 2) step();
    checks++;
    if (n_out - out0 != 100) begin errors++; $display("FAIL b2b_count: got %0d, want 100", n_out - out0); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_pending: got %0d, want 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int in0 = n_in;
    int out0 = n_out;
    track_lat = 0;
    for (int i = 0; i < 300; i++) begin
      drive_rand($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (STAGES + 4) step();
    checks++;
    if (n_out - out0 != n_in - in0) begin errors++; $display("FAIL bp_count: got %0d outputs, want %0d", n_out - out0, n_in - in0); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL bp_pending: got %0d, want 0", exp_q.size()); end
  endtask

  task automatic test_reset_midflight();
    int n = 0;
    track_lat = 1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin drive_rand(1'b1); step(); end
    in_valid = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_flush: got out_valid=%b, want 0", out_valid); end
      step();
    end
    drive_rand(1'b1);
    step();
    in_valid = 1'b0;
    while (!out_valid && n < 10) begin step(); n++; end
    checks++;
    if (n + 1 != STAGES) begin errors++; $display("FAIL midreset_latency: got %0d, want %0d", n + 1, STAGES); end
    step();
  endtask

  initial begin
    test_reset();
    test_directed("add_ripple", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    test_directed("sub_borrow", 32'h0000_0005, 32'h7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    test_directed("sub_ovf",    32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    test_directed("add_ovf",    32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
